program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/program_loader_word_packer.sv | 54 +++++
 rtl/program_loader.sv | 151 +++++++++++++++
 tb/tb_program_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants for the byte-stream program loader: FSM encoding, word and lane geometry.
package program_loader_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LANES      = 4;
    localparam int unsigned LANE_W     = $clog2(LANES);
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned STATE_W    = 3;

    localparam logic [STATE_W-1:0] ST_LEN  = 3'd0;
    localparam logic [STATE_W-1:0] ST_DATA = 3'd1;
    localparam logic [STATE_W-1:0] ST_CSUM = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN  = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/program_loader_word_packer.sv
// Little-endian byte-to-word assembler; pulses word_done_o the cycle after the fourth byte lands.
module word_packer
    import program_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               valid_i,
    input  logic [BYTE_W-1:0]  byte_i,
    output logic [INSTR_W-1:0] word_o,
    output logic [LANE_W-1:0]  lane_o,
    output logic               word_done_o
);

    logic [INSTR_W-1:0] word_q, word_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic               done_q, done_d;

    // Shift right so the first byte of a word ends up in bits 7:0.
    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        done_d = 1'b0;
        if (clr_i) begin
            word_d = '0;
            lane_d = '0;
        end else if (valid_i) begin
            word_d = {byte_i, word_q[INSTR_W-1:BYTE_W]};
            if (lane_q == LANE_W'(LANES - 1)) begin
                lane_d = '0;
                done_d = 1'b1;
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            lane_q <= '0;
            done_q <= 1'b0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
            done_q <= done_d;
        end
    end

    assign word_o      = word_q;
    assign lane_o      = lane_q;
    assign word_done_o = done_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and
// releases the core from reset once the image is verified.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               byte_valid,
    input  logic [BYTE_W-1:0]  byte_data,
    output logic               byte_ready,
    input  logic               reload,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_rst,
    output logic               done,
    output logic               error
);

    localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [STATE_W-1:0] state_q, state_d;
    logic [BYTE_W-1:0]  len_q, len_d;
    logic [BYTE_W-1:0]  csum_q, csum_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               ready_q, ready_d;
    logic               core_rst_q, core_rst_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               xfer_c;
    logic               pk_valid_c;
    logic [INSTR_W-1:0] pk_word;
    logic [LANE_W-1:0]  pk_lane;
    logic               pk_done;

    // A byte offered alongside reload is refused, so upstream never loses it.
    assign xfer_c     = byte_valid & ready_q & ~reload;
    assign pk_valid_c = xfer_c & (state_q == ST_DATA);

    word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (reload),
        .valid_i     (pk_valid_c),
        .byte_i      (byte_data),
        .word_o      (pk_word),
        .lane_o      (pk_lane),
        .word_done_o (pk_done)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        idle_d  = idle_q;

        // Address advances at the end of each write cycle and doubles as the word counter.
        if (pk_done) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_LEN: begin
                idle_d = '0;
                if (xfer_c) begin
                    if (byte_data == '0) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d   = byte_data;
                        csum_d  = '0;
                        addr_d  = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA, ST_CSUM: begin
                if (xfer_c) begin
                    idle_d = '0;
                    if (state_q == ST_DATA) begin
                        csum_d = csum_q ^ byte_data;
                        if ((pk_lane == LANE_W'(LANES - 1)) &&
                            (addr_q == ADDR_W'(len_q - BYTE_W'(1)))) begin
                            state_d = ST_CSUM;
                        end
                    end else begin
                        state_d = (byte_data == csum_q) ? ST_RUN : ST_ERR;
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: begin
                idle_d = '0;
            end
        endcase

        if (reload) begin
            state_d = ST_LEN;
            len_d   = '0;
            csum_d  = '0;
            addr_d  = '0;
            idle_d  = '0;
        end

        ready_d    = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        core_rst_d = (state_d != ST_RUN);
        done_d     = (state_d == ST_RUN);
        error_d    = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LEN;
            len_q      <= '0;
            csum_q     <= '0;
            addr_q     <= '0;
            idle_q     <= '0;
            ready_q    <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            addr_q     <= addr_d;
            idle_q     <= idle_d;
            ready_q    <= ready_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign byte_ready = ready_q & ~reload;
    assign imem_we    = pk_done;
    assign imem_addr  = addr_q;
    assign imem_wdata = pk_word;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a stream-level model of expected writes and outcome.
module tb_program_loader;

    localparam int unsigned ADDR_W  = 8;
    localparam int          TIMEOUT = 1023;
    localparam int          OC_RUN  = 1;
    localparam int          OC_ERR  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    logic [7:0]  dat [0:1023];
    int unsigned exp_addr[$], exp_data[$];
    int unsigned obs_addr[$], obs_data[$], obs_cyc[$];

    program_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            obs_addr.push_back(32'(imem_addr));
            obs_data.push_back(imem_wdata);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected memory image and final state derived from the stream rules alone.
    task automatic model_load(input int n, input logic [7:0] cs, input int stall_at,
                              input int stall_len, output int outcome);
        int         nb;
        logic [7:0] x;
        logic       timed_out;
        if (n == 0) begin
            outcome = OC_ERR;
            return;
        end
        timed_out = (stall_at >= 0) && (stall_at <= 4 * n) && (stall_len >= TIMEOUT);
        nb = timed_out ? stall_at : 4 * n;
        for (int w = 0; w < nb / 4; w++) begin
            exp_addr.push_back(32'(w));
            exp_data.push_back({dat[4*w+3], dat[4*w+2], dat[4*w+1], dat[4*w]});
        end
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x = x ^ dat[i];
        outcome = timed_out ? OC_ERR : ((cs == x) ? OC_RUN : OC_ERR);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int w);
        w = 0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        while (!byte_ready) begin
            w++;
            if (w > 64) begin
                check("ready_wait", 32'(byte_ready), 32'd1);
                byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic drive_load(input int n, input logic [7:0] cs, input int gap_max,
                              input int stall_at, input int stall_len, output int waits);
        int w;
        int g;
        waits = 0;
        @(posedge clk);
        #1;
        send_byte(8'(n), 0, w);
        if (n == 0) return;
        for (int i = 0; i <= 4 * n; i++) begin
            g = (i == stall_at) ? stall_len : int'($urandom_range(0, gap_max));
            if (g >= TIMEOUT) begin
                byte_valid = 1'b0;
                repeat (g) @(posedge clk);
                #1;
                return;
            end
            send_byte((i < 4 * n) ? dat[i] : cs, g, w);
            waits += w;
        end
    endtask

    task automatic check_outcome(input string tag, input int outcome);
        @(negedge clk);
        check({tag, "_done"},  32'(done),       32'(outcome == OC_RUN));
        check({tag, "_error"}, 32'(error),      32'(outcome == OC_ERR));
        check({tag, "_crst"},  32'(core_rst),   32'(outcome != OC_RUN));
        check({tag, "_rdy"},   32'(byte_ready), 32'd0);
    endtask

    task automatic compare_writes(input string tag);
        int m;
        repeat (3) @(negedge clk);
        check({tag, "_nwr"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_addr"}, obs_addr[i], exp_addr[i]);
            check({tag, "_data"}, obs_data[i], exp_data[i]);
        end
        exp_addr.delete(); exp_data.delete();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    endtask

    task automatic do_reload(input logic with_byte);
        @(posedge clk);
        #1;
        reload     = 1'b1;
        byte_valid = with_byte;
        byte_data  = 8'hA5;
        @(negedge clk);
        check("reload_rdy_gated", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;
        reload     = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        check("reload_done",  32'(done),       32'd0);
        check("reload_error", 32'(error),      32'd0);
        check("reload_crst",  32'(core_rst),   32'd1);
        check("reload_rdy",   32'(byte_ready), 32'd1);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < 4 * n; i++) dat[i] = 8'($urandom_range(0, 255));
    endtask

    function automatic logic [7:0] xor_of(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x = x ^ dat[i];
        return x;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int oc, w, n, stall_at, stall_len;
        logic [7:0] cs;

        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; reload = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy",   32'(byte_ready), 32'd0);
        check("rst_we",    32'(imem_we),    32'd0);
        check("rst_addr",  32'(imem_addr),  32'd0);
        check("rst_wdata", imem_wdata,      32'd0);
        check("rst_crst",  32'(core_rst),   32'd1);
        check("rst_done",  32'(done),       32'd0);
        check("rst_error", 32'(error),      32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_after_rst", 32'(byte_ready), 32'd1);

        // Single-word image with a correct checksum.
        dat[0] = 8'h13; dat[1] = 8'h00; dat[2] = 8'h00; dat[3] = 8'h80;
        model_load(1, 8'h93, -1, 0, oc);
        drive_load(1, 8'h93, 0, -1, 0, w);
        check_outcome("n1", oc);
        compare_writes("n1");

        // Two words, continuous valid: no stalls, writes four cycles apart.
        do_reload(1'b0);
        fill_random(2);
        cs = xor_of(2);
        model_load(2, cs, -1, 0, oc);
        drive_load(2, cs, 0, -1, 0, w);
        check("n2_waits", 32'(w), 32'd0);
        check_outcome("n2", oc);
        check("n2_spacing", (obs_cyc.size() >= 2) ? (obs_cyc[1] - obs_cyc[0]) : 32'd0, 32'd4);
        compare_writes("n2");

        // Wrong checksum.
        do_reload(1'b0);
        dat[0] = 8'h13; dat[1] = 8'h00; dat[2] = 8'h00; dat[3] = 8'h80;
        model_load(1, 8'h00, -1, 0, oc);
        drive_load(1, 8'h00, 0, -1, 0, w);
        check_outcome("badcs", oc);
        repeat (10) @(posedge clk);
        compare_writes("badcs");

        // Zero length.
        do_reload(1'b0);
        model_load(0, 8'h00, -1, 0, oc);
        drive_load(0, 8'h00, 0, -1, 0, w);
        check_outcome("len0", oc);
        compare_writes("len0");

        // Stall exactly at and just below the timeout after two data bytes.
        do_reload(1'b0);
        fill_random(1);
        cs = xor_of(1);
        model_load(1, cs, 2, TIMEOUT, oc);
        drive_load(1, cs, 0, 2, TIMEOUT, w);
        check_outcome("stall_to", oc);
        compare_writes("stall_to");
        do_reload(1'b0);
        model_load(1, cs, 2, TIMEOUT - 1, oc);
        drive_load(1, cs, 0, 2, TIMEOUT - 1, w);
        check_outcome("stall_ok", oc);
        compare_writes("stall_ok");

        // Reload mid-word: partial word discarded, fresh load starts clean.
        do_reload(1'b0);
        fill_random(1);
        @(posedge clk); #1;
        send_byte(8'd1, 0, w);
        send_byte(dat[0], 0, w);
        send_byte(dat[1], 0, w);
        do_reload(1'b1);
        fill_random(1);
        cs = xor_of(1);
        model_load(1, cs, -1, 0, oc);
        drive_load(1, cs, 1, -1, 0, w);
        check_outcome("midreload", oc);
        compare_writes("midreload");

        // Reset after word 0 is written, then a fresh single-word load.
        do_reload(1'b0);
        fill_random(2);
        @(posedge clk); #1;
        send_byte(8'd2, 0, w);
        for (int i = 0; i < 4; i++) send_byte(dat[i], 0, w);
        exp_addr.push_back(32'd0);
        exp_data.push_back({dat[3], dat[2], dat[1], dat[0]});
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_crst", 32'(core_rst),   32'd1);
        check("arst_rdy",  32'(byte_ready), 32'd0);
        check("arst_addr", 32'(imem_addr),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        fill_random(1);
        cs = xor_of(1);
        model_load(1, cs, -1, 0, oc);
        drive_load(1, cs, 0, -1, 0, w);
        check_outcome("after_rst", oc);
        compare_writes("after_rst");
        do_reload(1'b1);

        // Longest image: last address 254.
        fill_random(255);
        cs = xor_of(255);
        model_load(255, cs, -1, 0, oc);
        drive_load(255, cs, 0, -1, 0, w);
        check_outcome("n255", oc);
        compare_writes("n255");

        // Random images, gaps, checksums and occasional long stalls.
        for (int it = 0; it < 16; it++) begin
            do_reload(1'(it % 2));
            n = int'($urandom_range(1, 12));
            fill_random(n);
            cs = xor_of(n);
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            stall_at = -1;
            stall_len = 0;
            if ($urandom_range(0, 4) == 0) begin
                stall_at  = int'($urandom_range(0, 4 * n));
                stall_len = ($urandom_range(0, 1) == 0) ? TIMEOUT : TIMEOUT - 1;
            end
            model_load(n, cs, stall_at, stall_len, oc);
            drive_load(n, cs, 3, stall_at, stall_len, w);
            check_outcome("rand", oc);
            compare_writes("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
